// File: rtl/debug_cmd_pkg.sv
// Shared types and bit-position helpers for the debug command engine.
package debug_cmd_pkg;

    // DR scan state: IDLE until a capture, CAPT after capture, SHIFT once bits move.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAPT  = 2'd1,
        SHIFT = 2'd2
    } dbg_state_e;

    // Sticky overrun flag lands in the top bit of the captured word.
    function automatic int stat_ovr(input int dr_w);
        return dr_w - 1;
    endfunction

    // Sticky length-error flag sits just below the overrun flag.
    function automatic int stat_len(input int dr_w);
        return dr_w - 2;
    endfunction

    // Top bit of a command word selects take_action vs take_no_action.
    function automatic int action_bit(input int dr_w);
        return dr_w - 1;
    endfunction

endpackage

// File: rtl/debug_cmd_buffer.sv
// Single-entry valid/ready command holding register with action pulse generation.
module debug_cmd_buffer
    import debug_cmd_pkg::*;
#(
    parameter int IR_W = 2,
    parameter int DR_W = 38
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load_i,
    input  logic [DR_W-1:0]      word_i,
    input  logic [IR_W-1:0]      ch_i,
    input  logic                 cmd_ready_i,
    output logic [DR_W-1:0]      jdo_o,
    output logic [IR_W-1:0]      cmd_ch_o,
    output logic                 cmd_valid_o,
    output logic [2**IR_W-1:0]   take_action_o,
    output logic [2**IR_W-1:0]   take_no_action_o,
    output logic                 drop_o
);
    localparam int NUM_CH = 2**IR_W;
    localparam int ACT    = action_bit(DR_W);
    localparam logic [NUM_CH-1:0] ONE = {{(NUM_CH-1){1'b0}}, 1'b1};

    logic [DR_W-1:0]   jdo_q, jdo_d;
    logic [IR_W-1:0]   ch_q, ch_d;
    logic              valid_q, valid_d;
    logic [NUM_CH-1:0] act_q, act_d, noact_q, noact_d;
    logic              xfer, accept;
    logic [NUM_CH-1:0] ch_oh;

    // A new word is taken when the slot is empty or being drained this cycle;
    // otherwise it is dropped and reported upward.
    always_comb begin
        xfer    = valid_q & cmd_ready_i;
        accept  = load_i & (~valid_q | cmd_ready_i);
        drop_o  = load_i & valid_q & ~cmd_ready_i;
        valid_d = accept | (valid_q & ~cmd_ready_i);
        jdo_d   = jdo_q;
        ch_d    = ch_q;
        if (accept) begin
            jdo_d = word_i;
            ch_d  = ch_i;
        end
        ch_oh   = ONE << ch_q;
        act_d   = (xfer &  jdo_q[ACT]) ? ch_oh : '0;
        noact_d = (xfer & ~jdo_q[ACT]) ? ch_oh : '0;
    end

    // Holding register and one-cycle pulses for the word that just transferred.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            jdo_q   <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            act_q   <= '0;
            noact_q <= '0;
        end else begin
            jdo_q   <= jdo_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            act_q   <= act_d;
            noact_q <= noact_d;
        end
    end

    assign jdo_o            = jdo_q;
    assign cmd_ch_o         = ch_q;
    assign cmd_valid_o      = valid_q;
    assign take_action_o    = act_q;
    assign take_no_action_o = noact_q;

endmodule

// File: rtl/debug_cmd_engine.sv
// Debug data-register front end: IR, capture/shift/update scan FSM and status flags.
module debug_cmd_engine
    import debug_cmd_pkg::*;
#(
    parameter int IR_W      = 2,
    parameter int DR_W      = 38,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [IR_W-1:0]           ir_in,
    input  logic                      vs_uir,
    input  logic                      vs_cdr,
    input  logic                      vs_sdr,
    input  logic                      vs_udr,
    input  logic                      tdi,
    output logic                      tdo,
    input  logic [(2**IR_W)*DR_W-1:0] rd_data,
    output logic [DR_W-1:0]           jdo,
    output logic [IR_W-1:0]           cmd_ch,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [2**IR_W-1:0]        take_action,
    output logic [2**IR_W-1:0]        take_no_action,
    output logic                      overrun,
    output logic                      len_err
);
    localparam int CW = $clog2(DR_W + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(DR_W);
    localparam logic [CW-1:0] CNT_SAT  = CW'(DR_W + 1);
    localparam int S_OVR = stat_ovr(DR_W);
    localparam int S_LEN = stat_len(DR_W);

    logic [IR_W-1:0] ir_q, ir_d;
    logic [DR_W-1:0] sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    dbg_state_e      state_q, state_d;
    logic            ovr_q, ovr_d, len_q, len_d;
    logic [DR_W-1:0] rd_word;
    logic            upd_ok, load, drop;

    // An update only counts when no higher-priority strobe is present and bits were shifted.
    assign upd_ok = vs_udr & ~vs_uir & ~vs_cdr & ~vs_sdr & (state_q == SHIFT);
    assign load   = upd_ok & (cnt_q == CNT_FULL);

    // Next-state for IR, shift register, bit counter, FSM and sticky status.
    always_comb begin
        ir_d    = ir_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        ovr_d   = ovr_q;
        len_d   = len_q;
        rd_word = rd_data[int'(ir_q)*DR_W +: DR_W];
        if (vs_uir) begin
            ir_d    = ir_in;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (vs_cdr) begin
            // Status is reported with its pre-clear value, then cleared.
            sr_d        = rd_word;
            sr_d[S_OVR] = ovr_q;
            sr_d[S_LEN] = len_q;
            ovr_d       = 1'b0;
            len_d       = 1'b0;
            cnt_d       = '0;
            state_d     = CAPT;
        end else if (vs_sdr) begin
            if (state_q != IDLE) begin
                if (LSB_FIRST) sr_d = {tdi, sr_q[DR_W-1:1]};
                else           sr_d = {sr_q[DR_W-2:0], tdi};
                cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
                state_d = SHIFT;
            end
        end else if (upd_ok) begin
            state_d = IDLE;
            if (cnt_q != CNT_FULL) len_d = 1'b1;
            else if (drop)         ovr_d = 1'b1;
        end
    end

    // Scan state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ir_q    <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            ovr_q   <= 1'b0;
            len_q   <= 1'b0;
        end else begin
            ir_q    <= ir_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            ovr_q   <= ovr_d;
            len_q   <= len_d;
        end
    end

    assign tdo     = LSB_FIRST ? sr_q[0] : sr_q[DR_W-1];
    assign overrun = ovr_q;
    assign len_err = len_q;

    debug_cmd_buffer #(.IR_W(IR_W), .DR_W(DR_W)) u_buf (
        .clk              (clk),
        .reset_n          (reset_n),
        .load_i           (load),
        .word_i           (sr_q),
        .ch_i             (ir_q),
        .cmd_ready_i      (cmd_ready),
        .jdo_o            (jdo),
        .cmd_ch_o         (cmd_ch),
        .cmd_valid_o      (cmd_valid),
        .take_action_o    (take_action),
        .take_no_action_o (take_no_action),
        .drop_o           (drop)
    );

endmodule

// File: tb/tb_debug_cmd_engine.sv
// Directed bench for debug_cmd_engine: LSB-first instance plus a mirrored MSB-first instance.
module tb_debug_cmd_engine;
    localparam int IR_W = 2;
    localparam int DR_W = 38;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       ir_in;
    logic             vs_uir, vs_cdr, vs_sdr, vs_udr, tdi, cmd_ready;
    logic [4*DR_W-1:0] rd_data;

    logic             tdo, cmd_valid, overrun, len_err;
    logic [DR_W-1:0]  jdo;
    logic [1:0]       cmd_ch;
    logic [3:0]       take_action, take_no_action;

    logic             m_tdo, m_cmd_valid, m_overrun, m_len_err;
    logic [DR_W-1:0]  m_jdo;
    logic [1:0]       m_cmd_ch;
    logic [3:0]       m_take_action, m_take_no_action;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    debug_cmd_engine #(.IR_W(IR_W), .DR_W(DR_W), .LSB_FIRST(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .vs_uir(vs_uir), .vs_cdr(vs_cdr),
        .vs_sdr(vs_sdr), .vs_udr(vs_udr), .tdi(tdi), .tdo(tdo), .rd_data(rd_data),
        .jdo(jdo), .cmd_ch(cmd_ch), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .take_action(take_action), .take_no_action(take_no_action),
        .overrun(overrun), .len_err(len_err)
    );

    debug_cmd_engine #(.IR_W(IR_W), .DR_W(DR_W), .LSB_FIRST(1'b0)) u_mir (
        .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .vs_uir(vs_uir), .vs_cdr(vs_cdr),
        .vs_sdr(vs_sdr), .vs_udr(vs_udr), .tdi(tdi), .tdo(m_tdo), .rd_data(rd_data),
        .jdo(m_jdo), .cmd_ch(m_cmd_ch), .cmd_valid(m_cmd_valid), .cmd_ready(cmd_ready),
        .take_action(m_take_action), .take_no_action(m_take_no_action),
        .overrun(m_overrun), .len_err(m_len_err)
    );

    typedef struct {
        logic [1:0]  ir;
        logic [63:0] word;
        int          nbits;
        logic        exp_valid;
        logic [3:0]  exp_act;
        logic [3:0]  exp_noact;
        logic        exp_len;
    } vec_t;

    vec_t vecs [0:6];

    localparam logic [37:0] RD0 = 38'h00_0000_1110;
    localparam logic [37:0] RD1 = 38'h0A_5A5A_5A5A;
    localparam logic [37:0] RD2 = 38'h12_3456_789B;
    localparam logic [37:0] RD3 = 38'h3C_0F0F_0F0F;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [37:0] rev38(input logic [37:0] w);
        for (int i = 0; i < 38; i++) rev38[i] = w[37-i];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_uir(input logic [1:0] ir);
        ir_in = ir; vs_uir = 1'b1; tick(); vs_uir = 1'b0;
    endtask

    task automatic do_cdr();
        vs_cdr = 1'b1; tick(); vs_cdr = 1'b0;
    endtask

    task automatic do_udr();
        vs_udr = 1'b1; tick(); vs_udr = 1'b0;
    endtask

    // Bits go out LSB first so an LSB-first register ends up holding w exactly.
    task automatic shift_word(input logic [63:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            tdi = w[i]; vs_sdr = 1'b1; tick();
        end
        vs_sdr = 1'b0; tdi = 1'b0;
    endtask

    initial begin
        logic [37:0] exp_sr;
        logic [3:0]  m_oh;

        // 38'h20_0000_0001 has bit 37 set, so it is an action command.
        vecs[0] = '{2'd2, 64'h10_0000_0001, 38, 1'b1, 4'b0000, 4'b0100, 1'b0};
        vecs[1] = '{2'd2, 64'h20_0000_0001, 38, 1'b1, 4'b0100, 4'b0000, 1'b0};
        vecs[2] = '{2'd1, 64'h0F_1234_5678, 38, 1'b1, 4'b0000, 4'b0010, 1'b0};
        vecs[3] = '{2'd0, 64'h3F_FFFF_FFFF, 38, 1'b1, 4'b0001, 4'b0000, 1'b0};
        vecs[4] = '{2'd3, 64'h15_5555_5555, 37, 1'b0, 4'b0000, 4'b0000, 1'b1};
        vecs[5] = '{2'd3, 64'h15_5555_5555, 39, 1'b0, 4'b0000, 4'b0000, 1'b1};
        vecs[6] = '{2'd3, 64'h2A_AAAA_AAAA, 38, 1'b1, 4'b1000, 4'b0000, 1'b0};

        reset_n = 1'b0; ir_in = 2'd0; vs_uir = 0; vs_cdr = 0; vs_sdr = 0; vs_udr = 0;
        tdi = 0; cmd_ready = 0;
        rd_data = {RD3, RD2, RD1, RD0};
        tick(); tick();
        chk("rst_valid", cmd_valid, 0);
        chk("rst_jdo", jdo, 0);
        chk("rst_take", {take_action, take_no_action}, 0);
        chk("rst_status", {overrun, len_err}, 0);
        chk("rst_tdo", tdo, 0);
        reset_n = 1'b1;
        tick();

        // Capture channel 1 and watch both bit orders on tdo.
        do_uir(2'd1);
        do_cdr();
        exp_sr = {2'b00, RD1[35:0]};
        for (int i = 0; i < 38; i++) begin
            chk("cap_tdo", tdo, exp_sr[i]);
            chk("cap_tdo_mirror", m_tdo, exp_sr[37-i]);
            shift_word(64'd0, 1);
        end

        // Table of single commands, consumer always ready.
        cmd_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            do_uir(vecs[k].ir);
            do_cdr();
            shift_word(vecs[k].word, vecs[k].nbits);
            do_udr();
            chk("vec_valid", cmd_valid, vecs[k].exp_valid);
            chk("vec_len_err", len_err, vecs[k].exp_len);
            chk("vec_m_valid", m_cmd_valid, vecs[k].exp_valid);
            chk("vec_m_len_err", m_len_err, vecs[k].exp_len);
            if (vecs[k].exp_valid) begin
                chk("vec_jdo", jdo, vecs[k].word[37:0]);
                chk("vec_ch", cmd_ch, vecs[k].ir);
                chk("vec_m_jdo", m_jdo, rev38(vecs[k].word[37:0]));
                chk("vec_m_ch", m_cmd_ch, vecs[k].ir);
            end
            tick();
            m_oh = vecs[k].exp_valid ? (4'b0001 << vecs[k].ir) : 4'b0000;
            chk("vec_take_action", take_action, vecs[k].exp_act);
            chk("vec_take_no_action", take_no_action, vecs[k].exp_noact);
            chk("vec_valid_drop", cmd_valid, 0);
            chk("vec_m_take_action", m_take_action, vecs[k].word[0] ? m_oh : 4'b0000);
            chk("vec_m_take_no_action", m_take_no_action, vecs[k].word[0] ? 4'b0000 : m_oh);
            tick();
            chk("vec_pulse_1clk", {take_action, take_no_action}, 0);
        end

        // Overrun: consumer stalled, second command dropped.
        cmd_ready = 1'b0;
        do_uir(2'd2);
        do_cdr(); shift_word(64'h15_5555_5555, 38); do_udr();
        chk("ovr_a_valid", cmd_valid, 1);
        do_cdr(); shift_word(64'h2B_CDEF_0123, 38); do_udr();
        chk("ovr_flag", overrun, 1);
        chk("ovr_m_flag", m_overrun, 1);
        chk("ovr_jdo_kept", jdo, 38'h15_5555_5555);
        chk("ovr_valid_held", cmd_valid, 1);
        do_cdr();
        chk("ovr_cleared", overrun, 0);
        chk("ovr_cap_bit0", tdo, RD2[0]);
        chk("ovr_m_cap_bit37", m_tdo, 1);
        shift_word(64'd0, 37);
        chk("ovr_cap_bit37", tdo, 1);
        cmd_ready = 1'b1;
        tick();
        chk("ovr_drain_valid", cmd_valid, 0);
        chk("ovr_drain_noact", take_no_action, 4'b0100);
        chk("ovr_m_drain_act", m_take_action, 4'b0100);
        tick();

        // Transfer of A coincides with load of B.
        cmd_ready = 1'b0;
        do_uir(2'd1);
        do_cdr(); shift_word(64'h3F_0000_0000, 38); do_udr();
        chk("b2b_a_ch", cmd_ch, 1);
        do_uir(2'd3);
        do_cdr(); shift_word(64'h01_2345_6789, 38);
        cmd_ready = 1'b1;
        do_udr();
        chk("b2b_valid", cmd_valid, 1);
        chk("b2b_jdo", jdo, 38'h01_2345_6789);
        chk("b2b_ch", cmd_ch, 3);
        chk("b2b_take_a", take_action, 4'b0010);
        chk("b2b_noact_a", take_no_action, 4'b0000);
        chk("b2b_no_ovr", overrun, 0);
        tick();
        chk("b2b_valid_drop", cmd_valid, 0);
        chk("b2b_take_b", take_no_action, 4'b1000);
        chk("b2b_act_b", take_action, 4'b0000);
        tick();
        chk("b2b_pulse_clr", {take_action, take_no_action}, 0);

        // vs_uir beats vs_udr in the same cycle.
        do_uir(2'd0);
        do_cdr(); shift_word(64'h11_1111_1111, 38);
        ir_in = 2'd3; vs_uir = 1'b1; vs_udr = 1'b1; tick(); vs_uir = 1'b0; vs_udr = 1'b0;
        chk("uir_udr_valid", cmd_valid, 0);
        chk("uir_udr_len", len_err, 0);
        do_udr();
        chk("udr_idle_ignored", cmd_valid, 0);
        do_cdr();
        chk("uir_udr_ir3_cap", tdo, RD3[0]);

        // Reset between the 10th and 11th shift.
        do_uir(2'd2);
        do_cdr(); shift_word(64'h3F_FFFF_FFFF, 10);
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        chk("mid_rst_valid", cmd_valid, 0);
        chk("mid_rst_jdo", jdo, 0);
        chk("mid_rst_ch", cmd_ch, 0);
        chk("mid_rst_take", {take_action, take_no_action}, 0);
        chk("mid_rst_status", {overrun, len_err}, 0);
        chk("mid_rst_tdo", tdo, 0);
        shift_word(64'h3F_FFFF_FFFF, 28);
        chk("mid_rst_shift_ignored", tdo, 0);
        do_udr();
        chk("mid_rst_udr_valid", cmd_valid, 0);
        chk("mid_rst_udr_len", len_err, 0);
        chk("mid_rst_udr_jdo", jdo, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
